// File: rtl/avalon_key_pio.sv
// avalon_key_pio: Avalon-MM input PIO with per-bit synchroniser, debounce,
// press edge capture and a maskable level interrupt for KEY/SW inputs.
// Ports: CLK, RST_N (async, active low), PIN_IN[WIDTH] raw board pins,
//   AVS_ADDRESS/READ/WRITE/WRITEDATA/READDATA slave (read latency 1),
//   IRQ level interrupt. Map: 0 DATA, 1 IRQMASK, 2 EDGECAP (W1C), 3 RAW.
module avalon_key_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] PIN_IN,
   input  logic [1:0]       AVS_ADDRESS,
   input  logic             AVS_READ,
   input  logic             AVS_WRITE,
   input  logic [31:0]      AVS_WRITEDATA,
   output logic [31:0]      AVS_READDATA,
   output logic             IRQ
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] pin_lvl;
   logic [WIDTH-1:0] sync_q1;
   logic [WIDTH-1:0] sync_q2;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] cap_q;
   logic [WIDTH-1:0] clr;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [31:0]      rd_word;
   logic             wr_mask;
   logic             wr_cap;
   logic             wdata_unused;

   // Polarity is fixed before the synchroniser so every flop resets to
   // the logical inactive level and reset release cannot look like a press.
   assign pin_lvl = ACTIVE_LOW ? ~PIN_IN : PIN_IN;

   assign wr_mask = AVS_WRITE && (AVS_ADDRESS == 2'd1);
   assign wr_cap  = AVS_WRITE && (AVS_ADDRESS == 2'd2);
   assign clr     = wr_cap ? AVS_WRITEDATA[WIDTH-1:0] : '0;

   // Only the low WIDTH bits of write data are meaningful.
   assign wdata_unused = ^AVS_WRITEDATA;

   // Each bit counts consecutive cycles of disagreement with DATA; any
   // agreement restarts the count, so only a stable new level is accepted.
   always_comb begin
      data_d = data_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_q2[i] != data_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               data_d[i] = sync_q2[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign rise = data_d & ~data_q;

   always_comb begin
      rd_word = '0;
      unique case (AVS_ADDRESS)
         2'd0: rd_word = 32'(data_q);
         2'd1: rd_word = 32'(mask_q);
         2'd2: rd_word = 32'(cap_q);
         2'd3: rd_word = 32'(sync_q2);
         default: rd_word = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q1      <= '0;
         sync_q2      <= '0;
         data_q       <= '0;
         mask_q       <= '0;
         cap_q        <= '0;
         AVS_READDATA <= '0;
         IRQ          <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync_q1 <= pin_lvl;
         sync_q2 <= sync_q1;
         data_q  <= data_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         if (wr_mask) begin
            mask_q <= AVS_WRITEDATA[WIDTH-1:0];
         end
         // A press on the same cycle as its clear survives.
         cap_q <= (cap_q & ~clr) | rise;
         IRQ   <= |(cap_q & mask_q);
         if (AVS_READ) begin
            AVS_READDATA <= rd_word;
         end
      end
   end

endmodule
